br_credit_sender_stage: RTL and testbench

// - Sender side of a credit-based link: accepts flits on a ready/valid push interface
//   and forwards them on a credit-gated pop interface that has no backpressure.
// - Each flit sent consumes one credit; each pop_credit pulse from the receiver returns one.
// - Sits between a local producer and the long-distance wire/pipeline toward the

---
 rtl/br_credit_sender_stage_pkg.sv | 12 +
 rtl/br_credit_counter.sv | 59 +++++
 rtl/br_credit_sender_stage.sv | 94 +++++++++
 tb/tb_br_credit_sender_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_credit_sender_stage_pkg.sv
// Shared constants and helpers for the credit sender stage and its counter.
package br_credit_sender_stage_pkg;

  // A sender moves at most one credit per cycle in each direction.
  localparam int unsigned CREDIT_CHANGE_MAX = 1;

  // Bits needed to hold every value in 0..max_value.
  function automatic int unsigned count_width(input int unsigned max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/br_credit_counter.sv
// Credit counter: holds a credit count and reports usable credits after withholding.
// An increment is usable in the same cycle it arrives.
module br_credit_counter
  import br_credit_sender_stage_pkg::*;
#(
  parameter int MaxValue = 1,
  parameter int MaxChange = 1,
  localparam int ValueWidth = count_width(MaxValue),
  localparam int ChangeWidth = count_width(MaxChange)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   incr_valid,
  input  logic [ChangeWidth-1:0] incr,
  output logic                   decr_ready,
  input  logic                   decr_valid,
  input  logic [ChangeWidth-1:0] decr,
  input  logic [ValueWidth-1:0]  initial_value,
  input  logic [ValueWidth-1:0]  withhold,
  output logic [ValueWidth-1:0]  value,
  output logic [ValueWidth-1:0]  available
);

  // One extra bit so count + incr cannot wrap before the overflow check sees it.
  localparam int SumWidth = ValueWidth + 1;

  logic [SumWidth-1:0] incr_ext;
  logic [SumWidth-1:0] with_incr;
  logic [SumWidth-1:0] avail_ext;
  logic [SumWidth-1:0] decr_ext;
  logic [SumWidth-1:0] value_next;
  logic                decr_fire;

  // Usable credits, decrement handshake and next count.
  always_comb begin
    incr_ext = '0;
    if (incr_valid && !rst) incr_ext = SumWidth'(incr);
    with_incr = {1'b0, value} + incr_ext;
    avail_ext = '0;
    if (with_incr > {1'b0, withhold}) avail_ext = with_incr - {1'b0, withhold};
    available = avail_ext[ValueWidth-1:0];
    if (avail_ext > SumWidth'(MaxValue)) available = ValueWidth'(MaxValue);
    decr_ready = !rst && (avail_ext >= SumWidth'(decr));
    decr_fire = decr_valid && decr_ready;
    decr_ext = decr_fire ? SumWidth'(decr) : '0;
    value_next = with_incr - decr_ext;
  end

  // Count register; reset keeps reloading the initial credit count.
  always_ff @(posedge clk) begin
    if (rst) value <= initial_value;
    else value <= value_next[ValueWidth-1:0];
  end

  assert property (@(posedge clk) disable iff (rst) value_next <= SumWidth'(MaxValue));
  assert property (@(posedge clk) $fell(rst) |-> $past(initial_value) <= ValueWidth'(MaxValue));
  assert property (@(posedge clk) withhold <= ValueWidth'(MaxValue));

endmodule

// File: rtl/br_credit_sender_stage.sv
// Sender side of a credit-based link: ready/valid push in, credit-gated pop out.
// Each sent flit consumes a credit; each pop_credit pulse returns one.
module br_credit_sender_stage
  import br_credit_sender_stage_pkg::*;
#(
  parameter int Width = 1,
  parameter int MaxCredit = 1,
  parameter bit RegisterPopOutputs = 1,
  parameter bit RegisterPopCredit = 0,
  localparam int CountWidth = $clog2(MaxCredit + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_credit_stall,
  output logic                  push_ready,
  input  logic                  push_valid,
  input  logic [Width-1:0]      push_data,
  output logic                  pop_valid,
  output logic [Width-1:0]      pop_data,
  input  logic                  pop_credit,
  input  logic [CountWidth-1:0] credit_initial,
  input  logic [CountWidth-1:0] credit_withhold,
  output logic [CountWidth-1:0] credit_count,
  output logic [CountWidth-1:0] credit_available
);

  logic incr;
  logic counter_ready;
  logic send;

  if (RegisterPopCredit) begin : g_credit_flop
    logic pop_credit_q;
    // Retime the returned credit; anything in flight is dropped by reset.
    always_ff @(posedge clk) begin
      if (!rst_n) pop_credit_q <= 1'b0;
      else pop_credit_q <= pop_credit;
    end
    assign incr = pop_credit_q;
  end else begin : g_credit_comb
    assign incr = pop_credit;
  end

  br_credit_counter #(
    .MaxValue (MaxCredit),
    .MaxChange(CREDIT_CHANGE_MAX)
  ) u_counter (
    .clk          (clk),
    .rst          (!rst_n),
    .incr_valid   (incr),
    .incr         (1'b1),
    .decr_ready   (counter_ready),
    .decr_valid   (push_valid && !push_credit_stall),
    .decr         (1'b1),
    .initial_value(credit_initial),
    .withhold     (credit_withhold),
    .value        (credit_count),
    .available    (credit_available)
  );

  // Ready is independent of push_valid so the producer may wait on it.
  assign push_ready = rst_n && !push_credit_stall && counter_ready;
  assign send = push_valid && push_ready;

  if (RegisterPopOutputs) begin : g_pop_flop
    logic             pop_valid_q;
    logic [Width-1:0] pop_data_q;
    // Launch flop toward the link; data only moves on a send.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pop_valid_q <= 1'b0;
        pop_data_q  <= '0;
      end else begin
        pop_valid_q <= send;
        if (send) pop_data_q <= push_data;
      end
    end
    assign pop_valid = pop_valid_q;
    assign pop_data  = pop_data_q;

    assert property (@(posedge clk) disable iff (!rst_n) pop_valid_q |-> $past(send));
  end else begin : g_pop_comb
    assign pop_valid = send;
    assign pop_data  = push_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    push_valid && !push_ready |=> push_valid && $stable(push_data));

  cover property (@(posedge clk) disable iff (!rst_n) credit_count == '0);
  cover property (@(posedge clk) disable iff (!rst_n) credit_count == CountWidth'(MaxCredit));
  cover property (@(posedge clk) disable iff (!rst_n) push_credit_stall && push_valid);
  cover property (@(posedge clk) disable iff (!rst_n) incr && send);

endmodule

// File: tb/tb_br_credit_sender_stage.sv
// Directed bench for br_credit_sender_stage: flopped-output/same-cycle-credit
// instance plus a combinational-output/flopped-credit instance.
module tb_br_credit_sender_stage;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       stall, push_valid, pop_credit;
  logic [7:0] push_data;
  logic [3:0] credit_initial, credit_withhold;
  logic       push_ready, pop_valid;
  logic [7:0] pop_data;
  logic [3:0] credit_count, credit_available;

  logic       b_stall, b_push_valid, b_pop_credit;
  logic [7:0] b_push_data;
  logic [3:0] b_credit_initial, b_credit_withhold;
  logic       b_push_ready, b_pop_valid;
  logic [7:0] b_pop_data;
  logic [3:0] b_credit_count, b_credit_available;

  int vec_cnt = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  br_credit_sender_stage #(
    .Width(8), .MaxCredit(8), .RegisterPopOutputs(1), .RegisterPopCredit(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .push_credit_stall(stall), .push_ready(push_ready),
    .push_valid(push_valid), .push_data(push_data), .pop_valid(pop_valid),
    .pop_data(pop_data), .pop_credit(pop_credit), .credit_initial(credit_initial),
    .credit_withhold(credit_withhold), .credit_count(credit_count),
    .credit_available(credit_available)
  );

  br_credit_sender_stage #(
    .Width(8), .MaxCredit(8), .RegisterPopOutputs(0), .RegisterPopCredit(1)
  ) u_dut_rc (
    .clk(clk), .rst_n(rst_n), .push_credit_stall(b_stall), .push_ready(b_push_ready),
    .push_valid(b_push_valid), .push_data(b_push_data), .pop_valid(b_pop_valid),
    .pop_data(b_pop_data), .pop_credit(b_pop_credit), .credit_initial(b_credit_initial),
    .credit_withhold(b_credit_withhold), .credit_count(b_credit_count),
    .credit_available(b_credit_available)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int cnt_m, outst, rets, pops, sends;
    bit exp_rdy, snd;
    logic [7:0] q[$];

    rst_n = 0; stall = 0; push_valid = 0; push_data = 0; pop_credit = 0;
    credit_initial = 2; credit_withhold = 0;
    b_stall = 0; b_push_valid = 0; b_push_data = 0; b_pop_credit = 0;
    b_credit_initial = 0; b_credit_withhold = 0;
    nxt(); nxt();

    // reset: credits returned and pushes offered are ignored
    pop_credit = 1; push_valid = 1; push_data = 8'h55;
    #1;
    chk("rst_ready", push_ready, 0);
    nxt();
    chk("rst_count", credit_count, 2);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);

    // initial=2, push held: exactly two sends then stuck
    pulses = 0;
    pop_credit = 0; rst_n = 1; push_data = 8'hA1;
    #1;
    chk("t1_ready0", push_ready, 1);
    chk("t1_avail0", credit_available, 2);
    nxt(); pulses += pop_valid;
    chk("t1_count1", credit_count, 1);
    chk("t1_data1", pop_data, 8'hA1);
    push_data = 8'hA2;
    #1;
    chk("t1_ready1", push_ready, 1);
    nxt(); pulses += pop_valid;
    chk("t1_count2", credit_count, 0);
    chk("t1_data2", pop_data, 8'hA2);
    push_data = 8'hA3;
    #1;
    chk("t1_ready2", push_ready, 0);
    chk("t1_avail2", credit_available, 0);
    nxt(); pulses += pop_valid;
    nxt(); pulses += pop_valid;
    chk("t1_pulses", pulses, 2);
    chk("t1_count_end", credit_count, 0);

    // count=0, returned credit used the same cycle
    pop_credit = 1;
    #1;
    chk("t2_ready", push_ready, 1);
    chk("t2_avail", credit_available, 1);
    nxt();
    chk("t2_pop_valid", pop_valid, 1);
    chk("t2_pop_data", pop_data, 8'hA3);
    chk("t2_count", credit_count, 0);
    pop_credit = 0; push_valid = 0;
    #1;
    chk("t2_ready_after", push_ready, 0);

    // flopped credit: send lands one cycle after the return pulse
    b_push_valid = 1; b_push_data = 8'hB1; b_pop_credit = 1;
    #1;
    chk("t2b_ready0", b_push_ready, 0);
    chk("t2b_pop_valid0", b_pop_valid, 0);
    chk("t2b_avail0", b_credit_available, 0);
    nxt();
    b_pop_credit = 0;
    #1;
    chk("t2b_ready1", b_push_ready, 1);
    chk("t2b_pop_valid1", b_pop_valid, 1);
    chk("t2b_pop_data1", b_pop_data, 8'hB1);
    chk("t2b_avail1", b_credit_available, 1);
    nxt();
    b_push_valid = 0;
    #1;
    chk("t2b_count", b_credit_count, 0);
    chk("t2b_pop_valid2", b_pop_valid, 0);

    // withhold: initial=4, withhold=3 leaves one usable credit
    rst_n = 0; credit_initial = 4;
    nxt(); nxt();
    rst_n = 1; credit_withhold = 3; push_valid = 1; push_data = 8'hC1;
    #1;
    chk("t3_avail0", credit_available, 1);
    chk("t3_ready0", push_ready, 1);
    nxt();
    chk("t3_count1", credit_count, 3);
    chk("t3_pop_valid1", pop_valid, 1);
    chk("t3_data1", pop_data, 8'hC1);
    push_data = 8'hC2;
    #1;
    chk("t3_avail1", credit_available, 0);
    chk("t3_ready1", push_ready, 0);
    nxt();
    chk("t3_count2", credit_count, 3);
    chk("t3_pop_valid2", pop_valid, 0);
    chk("t3_data_hold", pop_data, 8'hC1);
    credit_withhold = 2;
    #1;
    chk("t3_ready_rel", push_ready, 1);
    nxt();
    chk("t3_count3", credit_count, 2);
    chk("t3_data3", pop_data, 8'hC2);
    push_valid = 0; credit_withhold = 3; pop_credit = 1;
    #1;
    chk("t3_avail_edge", credit_available, 0);
    chk("t3_ready_edge", push_ready, 0);
    nxt();
    chk("t3_count4", credit_count, 3);
    pop_credit = 0; credit_withhold = 0;

    // stall 3 cycles with 2 returns, then drain
    stall = 1; push_valid = 1; push_data = 8'hD1; pop_credit = 1;
    #1;
    chk("t4_ready_stall", push_ready, 0);
    nxt();
    chk("t4_count1", credit_count, 4);
    nxt();
    chk("t4_count2", credit_count, 5);
    pop_credit = 0;
    nxt();
    chk("t4_count3", credit_count, 5);
    chk("t4_pop_valid_stall", pop_valid, 0);
    stall = 0;
    #1;
    chk("t4_avail_rel", credit_available, 5);
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("t4_drain_valid", pop_valid, 1);
      chk("t4_drain_data", pop_data, 8'hD1 + 8'(k));
      chk("t4_drain_count", credit_count, 4 - k);
      push_data = 8'hD2 + 8'(k);
    end
    #1;
    chk("t4_ready_empty", push_ready, 0);
    nxt();
    chk("t4_pop_valid_end", pop_valid, 0);

    // reset with a flit in flight
    rst_n = 0; push_valid = 0; credit_initial = 3;
    nxt(); nxt();
    rst_n = 1; push_valid = 1; push_data = 8'hE1;
    nxt();
    chk("t5_inflight", pop_valid, 1);
    rst_n = 0; credit_initial = 5; push_data = 8'hE2;
    #1;
    chk("t5_ready_rst", push_ready, 0);
    nxt();
    chk("t5_pop_valid", pop_valid, 0);
    chk("t5_pop_data", pop_data, 0);
    chk("t5_count", credit_count, 5);
    push_valid = 0;

    // random push/return traffic against a credit model
    credit_initial = 3;
    nxt();
    rst_n = 1;
    cnt_m = 3; outst = 0; rets = 0; pops = 0; sends = 0;
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 5) == 0);
      pop_credit = (outst > 0) && ($urandom_range(0, 1) == 1);
      if (!push_valid && $urandom_range(0, 2) != 0) begin
        push_valid = 1;
        push_data = 8'($urandom_range(0, 255));
      end
      #1;
      exp_rdy = !stall && (cnt_m + int'(pop_credit) > 0);
      chk("rnd_ready", push_ready, exp_rdy);
      snd = push_valid && exp_rdy;
      if (snd) q.push_back(push_data);
      nxt();
      if (pop_credit) begin
        outst--;
        rets++;
      end
      cnt_m = cnt_m + int'(pop_credit) - int'(snd);
      chk("rnd_count", credit_count, cnt_m);
      chk("rnd_pop_valid", pop_valid, snd);
      if (pop_valid) begin
        pops++;
        if (q.size() > 0) chk("rnd_pop_data", pop_data, q.pop_front());
        else chk("rnd_pop_unexpected", pop_valid, 0);
      end
      if (snd) begin
        sends++;
        outst++;
        push_valid = 0;
      end
    end
    chk("rnd_pop_bound", (pops <= 3 + rets), 1);
    chk("rnd_pop_total", pops, sends);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
